// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_arb_pkg                                             |
// | Description : Shared types and widths for the data-memory arbiter.     |
// |               arb_state_t : arbiter FSM states (IDLE/L_BURST/YIELD)    |
// |               owner_t     : owner tag of the access in flight          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package dmem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    L_BURST = 2'd1,
    YIELD   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    PIPE   = 2'd1,
    LOADER = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_arbiter_if                                          |
// | Description : Bundle of pipeline, loader, memory and statistics        |
// |               signals around the data-memory arbiter.                  |
// |               modport slave  : arbiter side                            |
// |               modport master : environment side (requesters + memory)  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  // pipeline requester
  logic              p_req;
  logic              p_we;
  logic [SIZE_W-1:0] p_size;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_stall;
  logic              p_rvalid;
  logic [DATA_W-1:0] p_rdata;

  // loader requester
  logic              l_req;
  logic              l_lock;
  logic              l_we;
  logic [SIZE_W-1:0] l_size;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  // data memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [SIZE_W-1:0] mem_size;
  logic [DATA_W-1:0] mem_rdata;

  // statistics
  logic [31:0]       stat_p_stall_cnt;
  logic [31:0]       stat_l_grant_cnt;

  modport slave (
    input  p_req, p_we, p_size, p_addr, p_wdata,
    output p_gnt, p_stall, p_rvalid, p_rdata,
    input  l_req, l_lock, l_we, l_size, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, mem_size,
    input  mem_rdata,
    output stat_p_stall_cnt, stat_l_grant_cnt
  );

  modport master (
    output p_req, p_we, p_size, p_addr, p_wdata,
    input  p_gnt, p_stall, p_rvalid, p_rdata,
    output l_req, l_lock, l_we, l_size, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_size,
    output mem_rdata,
    input  stat_p_stall_cnt, stat_l_grant_cnt
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_burst_ctr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_arb_burst_ctr                                       |
// | Description : Loader burst length counter.                             |
// |   clk      in   clock                                                  |
// |   reset    in   synchronous active-low reset                           |
// |   i_clr    in   clear counter (with i_inc: load 1)                     |
// |   i_inc    in   count one loader grant                                 |
// |   o_at_max out  counter equals MAX_BURST                               |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module dmem_arb_burst_ctr #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clr,
  input  wire logic i_inc,
  output logic      o_at_max
);

  logic [CNT_W-1:0] r_cnt;

  // clear+inc together loads 1: the grant that starts a new burst counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_at_max = (r_cnt == CNT_W'(MAX_BURST));

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                             |
// | Description : Two-requester arbiter for the single data-memory port.   |
// |               Pipeline has priority; the loader may lock the port for  |
// |               up to MAX_BURST grants, then must yield for one cycle.   |
// |   clk    in   clock, rising edge                                       |
// |   reset  in   synchronous active-low reset                             |
// |   bus    slave modport of dmem_arbiter_if (requests, grants, stall,    |
// |          read return, memory port, statistics)                         |
// | Optional : DMEM_ARB_STATS_EN enables saturating stall/grant counters;  |
// |            otherwise the stat ports are tied to zero.                  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] C_ST_IDLE   = IDLE;
  localparam logic [1:0] C_ST_LBURST = L_BURST;
  localparam logic [1:0] C_ST_YIELD  = YIELD;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_p_gnt;
  logic       w_l_gnt;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_at_max;
  logic       w_use_idle;
  logic       w_sel_we;
  owner_t     r_owner;
  logic       r_read_q;
  logic       w_p_rvalid;
  logic       w_l_rvalid;

  dmem_arb_burst_ctr #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_burst_ctr (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .o_at_max (w_at_max)
  );

  // Arbitration and next state. Falling out of a burst re-arbitrates as
  // IDLE in the same cycle, so that path is shared via w_use_idle.
  always_comb begin
    w_p_gnt    = 1'b0;
    w_l_gnt    = 1'b0;
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_use_idle = 1'b0;

    case (r_state)
      C_ST_YIELD: begin
        w_next    = C_ST_IDLE;
        w_cnt_clr = 1'b1;
        if (bus.p_req) begin
          w_p_gnt = 1'b1;
        end else if (bus.l_req) begin
          w_l_gnt = 1'b1;
          if (bus.l_lock) begin
            w_next    = C_ST_LBURST;
            w_cnt_inc = 1'b1;
          end
        end
      end
      C_ST_LBURST: begin
        if (bus.l_req && bus.l_lock) begin
          if (w_at_max) begin
            // burst exhausted: idle cycle, pipeline gets the next slot
            w_next    = C_ST_YIELD;
            w_cnt_clr = 1'b1;
          end else begin
            w_l_gnt   = 1'b1;
            w_cnt_inc = 1'b1;
          end
        end else begin
          w_use_idle = 1'b1;
        end
      end
      default: w_use_idle = 1'b1;
    endcase

    if (w_use_idle) begin
      w_next    = C_ST_IDLE;
      w_cnt_clr = 1'b1;
      if (bus.p_req) begin
        w_p_gnt = 1'b1;
      end else if (bus.l_req) begin
        w_l_gnt = 1'b1;
        if (bus.l_lock) begin
          w_next    = C_ST_LBURST;
          w_cnt_inc = 1'b1;
        end
      end
    end

    if (!reset) begin
      w_p_gnt   = 1'b0;
      w_l_gnt   = 1'b0;
      w_cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= C_ST_IDLE;
      r_owner  <= NONE;
      r_read_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_owner  <= w_p_gnt ? PIPE : (w_l_gnt ? LOADER : NONE);
      r_read_q <= (w_p_gnt | w_l_gnt) & ~w_sel_we;
    end
  end

  // memory port mux
  assign w_sel_we      = w_p_gnt ? bus.p_we : (w_l_gnt ? bus.l_we : 1'b0);
  assign bus.mem_addr  = w_p_gnt ? bus.p_addr  : (w_l_gnt ? bus.l_addr  : '0);
  assign bus.mem_wdata = w_p_gnt ? bus.p_wdata : (w_l_gnt ? bus.l_wdata : '0);
  assign bus.mem_size  = w_p_gnt ? bus.p_size  : (w_l_gnt ? bus.l_size  : '0);
  assign bus.mem_we    = (w_p_gnt | w_l_gnt) & w_sel_we;
  assign bus.mem_re    = (w_p_gnt | w_l_gnt) & ~w_sel_we;

  assign bus.p_gnt   = w_p_gnt;
  assign bus.l_gnt   = w_l_gnt;
  assign bus.p_stall = reset & bus.p_req & ~w_p_gnt;

  // A read granted just before reset asserts must not surface while reset
  // is held, so the return valids are qualified by reset as well.
  assign w_p_rvalid   = reset & r_read_q & (r_owner == PIPE);
  assign w_l_rvalid   = reset & r_read_q & (r_owner == LOADER);
  assign bus.p_rvalid = w_p_rvalid;
  assign bus.l_rvalid = w_l_rvalid;
  assign bus.p_rdata  = w_p_rvalid ? bus.mem_rdata : '0;
  assign bus.l_rdata  = w_l_rvalid ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_p_stall;
  logic [31:0] r_stat_l_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_p_stall <= '0;
      r_stat_l_grant <= '0;
    end else begin
      if (bus.p_stall && (r_stat_p_stall != 32'hFFFF_FFFF)) begin
        r_stat_p_stall <= r_stat_p_stall + 32'd1;
      end
      if (w_l_gnt && (r_stat_l_grant != 32'hFFFF_FFFF)) begin
        r_stat_l_grant <= r_stat_l_grant + 32'd1;
      end
    end
  end

  assign bus.stat_p_stall_cnt = r_stat_p_stall;
  assign bus.stat_l_grant_cnt = r_stat_l_grant;
`else
  assign bus.stat_p_stall_cnt = '0;
  assign bus.stat_l_grant_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                          |
// | Description : Self-checking bench for dmem_arbiter. A behavioural      |
// |               model predicts grants, memory port, read return and      |
// |               statistics every cycle; directed scenarios add literal   |
// |               expectations.                                            |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic chk_en;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_burst: loader currently owns a locked burst, m_grants grants so far.
  // m_yield: the cycle right after an exhausted burst.
  logic        m_burst;
  logic        m_yield;
  int          m_grants;
  logic        m_pend_p;
  logic        m_pend_l;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_lgnt_cnt;

  // returns {pipeline_grant, loader_grant}
  function automatic logic [1:0] exp_gnt();
    if (!reset) return 2'b00;
    if (m_yield) return bus.p_req ? 2'b10 : (bus.l_req ? 2'b01 : 2'b00);
    if (m_burst && bus.l_req && bus.l_lock)
      return (m_grants >= MAX_BURST) ? 2'b00 : 2'b01;
    return bus.p_req ? 2'b10 : (bus.l_req ? 2'b01 : 2'b00);
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    g = exp_gnt();
    if (!reset) begin
      m_burst     <= 1'b0;
      m_yield     <= 1'b0;
      m_grants    <= 0;
      m_pend_p    <= 1'b0;
      m_pend_l    <= 1'b0;
      m_stall_cnt <= '0;
      m_lgnt_cnt  <= '0;
    end else begin
      m_pend_p <= g[1] & ~bus.p_we;
      m_pend_l <= g[0] & ~bus.l_we;
      if (m_burst && bus.l_req && bus.l_lock && (m_grants >= MAX_BURST)) begin
        m_burst  <= 1'b0;
        m_yield  <= 1'b1;
        m_grants <= 0;
      end else if (g[0] && bus.l_lock) begin
        m_burst  <= 1'b1;
        m_yield  <= 1'b0;
        m_grants <= (m_burst && !m_yield) ? m_grants + 1 : 1;
      end else begin
        m_burst  <= 1'b0;
        m_yield  <= 1'b0;
        m_grants <= 0;
      end
      if (bus.p_req && !g[1] && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 1;
      if (g[0] && m_lgnt_cnt != 32'hFFFF_FFFF) m_lgnt_cnt <= m_lgnt_cnt + 1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [1:0]  g;
    logic        we_sel;
    logic        e_prv;
    logic        e_lrv;
    if (chk_en) begin
      g      = exp_gnt();
      we_sel = g[1] ? bus.p_we : (g[0] ? bus.l_we : 1'b0);
      e_prv  = m_pend_p & reset;
      e_lrv  = m_pend_l & reset;
      chk("p_gnt", 32'(bus.p_gnt), 32'(g[1]));
      chk("l_gnt", 32'(bus.l_gnt), 32'(g[0]));
      chk("p_stall", 32'(bus.p_stall), 32'(reset & bus.p_req & ~g[1]));
      chk("mem_we", 32'(bus.mem_we), 32'((|g) & we_sel));
      chk("mem_re", 32'(bus.mem_re), 32'((|g) & ~we_sel));
      chk("mem_addr", bus.mem_addr, g[1] ? bus.p_addr : (g[0] ? bus.l_addr : 32'd0));
      chk("mem_wdata", bus.mem_wdata, g[1] ? bus.p_wdata : (g[0] ? bus.l_wdata : 32'd0));
      chk("mem_size", 32'(bus.mem_size), 32'(g[1] ? bus.p_size : (g[0] ? bus.l_size : 2'd0)));
      chk("p_rvalid", 32'(bus.p_rvalid), 32'(e_prv));
      chk("l_rvalid", 32'(bus.l_rvalid), 32'(e_lrv));
      chk("p_rdata", bus.p_rdata, e_prv ? bus.mem_rdata : 32'd0);
      chk("l_rdata", bus.l_rdata, e_lrv ? bus.mem_rdata : 32'd0);
`ifdef DMEM_ARB_STATS_EN
      chk("stat_p_stall", bus.stat_p_stall_cnt, m_stall_cnt);
      chk("stat_l_grant", bus.stat_l_grant_cnt, m_lgnt_cnt);
`else
      chk("stat_p_stall", bus.stat_p_stall_cnt, 32'd0);
      chk("stat_l_grant", bus.stat_l_grant_cnt, 32'd0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    bus.p_req     = 1'b0;
    bus.p_we      = 1'b0;
    bus.p_size    = 2'd0;
    bus.p_addr    = 32'd0;
    bus.p_wdata   = 32'd0;
    bus.l_req     = 1'b0;
    bus.l_lock    = 1'b0;
    bus.l_we      = 1'b0;
    bus.l_size    = 2'd0;
    bus.l_addr    = 32'd0;
    bus.l_wdata   = 32'd0;
    bus.mem_rdata = 32'hA5A5_A5A5;  // garbage: must never leak to rdata
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    reset    = 1'b0;
    clr_in();
    nxt();
    chk_en = 1'b1;

    // reset: request held, everything must stay quiet
    bus.p_req  = 1'b1;
    bus.p_addr = 32'h10;
    mid();
    chk("rst_p_gnt", 32'(bus.p_gnt), 32'd0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_p_stall", 32'(bus.p_stall), 32'd0);
    chk("rst_p_rvalid", 32'(bus.p_rvalid), 32'd0);
    nxt();
    reset = 1'b1;
    clr_in();
    nxt();

    // pipeline-only read
    bus.p_req  = 1'b1;
    bus.p_addr = 32'h10;
    bus.p_size = 2'd2;
    mid();
    chk("prd_p_gnt", 32'(bus.p_gnt), 32'd1);
    chk("prd_mem_re", 32'(bus.mem_re), 32'd1);
    chk("prd_mem_addr", bus.mem_addr, 32'h10);
    chk("prd_mem_size", 32'(bus.mem_size), 32'd2);
    chk("prd_p_stall", 32'(bus.p_stall), 32'd0);
    nxt();
    clr_in();
    bus.mem_rdata = 32'hDEAD_BEEF;
    mid();
    chk("prd_p_rvalid", 32'(bus.p_rvalid), 32'd1);
    chk("prd_p_rdata", bus.p_rdata, 32'hDEAD_BEEF);
    chk("prd_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    nxt();
    clr_in();

    // simultaneous, unlocked: pipeline wins, loader next
    bus.p_req  = 1'b1;
    bus.p_addr = 32'h14;
    bus.l_req  = 1'b1;
    bus.l_addr = 32'h80;
    mid();
    chk("both_p_gnt", 32'(bus.p_gnt), 32'd1);
    chk("both_l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("both_p_stall", 32'(bus.p_stall), 32'd0);
    nxt();
    bus.p_req = 1'b0;
    mid();
    chk("both_l_gnt2", 32'(bus.l_gnt), 32'd1);
    chk("both_mem_addr", bus.mem_addr, 32'h80);
    nxt();
    clr_in();
    nxt();

    // locked burst with pipeline waiting
    bus.l_req   = 1'b1;
    bus.l_lock  = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 32'h100;
    bus.l_wdata = 32'h0BAD_F00D;
    mid();
    chk("burst_first_l_gnt", 32'(bus.l_gnt), 32'd1);
    nxt();
    bus.p_req  = 1'b1;
    bus.p_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("burst_l_gnt", 32'(bus.l_gnt), 32'd1);
      chk("burst_p_stall", 32'(bus.p_stall), 32'd1);
      nxt();
    end
    mid();
    chk("burst_gap_l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("burst_gap_p_gnt", 32'(bus.p_gnt), 32'd0);
    chk("burst_gap_p_stall", 32'(bus.p_stall), 32'd1);
    nxt();
    mid();
    chk("yield_p_gnt", 32'(bus.p_gnt), 32'd1);
    chk("yield_mem_addr", bus.mem_addr, 32'h200);
    nxt();
    bus.p_req = 1'b0;
    mid();
    chk("resume_l_gnt", 32'(bus.l_gnt), 32'd1);
    nxt();
    clr_in();
    nxt();

    // locked burst, no pipeline: yield slot goes back to the loader
    bus.l_req  = 1'b1;
    bus.l_lock = 1'b1;
    bus.l_addr = 32'h300;
    for (int i = 0; i < 4; i++) nxt();
    mid();
    chk("solo_gap_l_gnt", 32'(bus.l_gnt), 32'd0);
    nxt();
    mid();
    chk("solo_yield_l_gnt", 32'(bus.l_gnt), 32'd1);
    nxt();
    for (int i = 0; i < 4; i++) nxt();
    clr_in();
    nxt();

    // alternating owners: P read, L read, P write
    bus.p_req  = 1'b1;
    bus.p_addr = 32'h20;
    nxt();
    clr_in();
    bus.l_req     = 1'b1;
    bus.l_addr    = 32'h40;
    bus.mem_rdata = 32'h1111_2222;
    mid();
    chk("alt_p_rvalid", 32'(bus.p_rvalid), 32'd1);
    chk("alt_p_rdata", bus.p_rdata, 32'h1111_2222);
    chk("alt_l_gnt", 32'(bus.l_gnt), 32'd1);
    nxt();
    clr_in();
    bus.p_req     = 1'b1;
    bus.p_we      = 1'b1;
    bus.p_addr    = 32'h24;
    bus.p_wdata   = 32'h5555_6666;
    bus.mem_rdata = 32'h3333_4444;
    mid();
    chk("alt_l_rvalid", 32'(bus.l_rvalid), 32'd1);
    chk("alt_l_rdata", bus.l_rdata, 32'h3333_4444);
    chk("alt_p_rvalid_off", 32'(bus.p_rvalid), 32'd0);
    chk("alt_mem_we", 32'(bus.mem_we), 32'd1);
    chk("alt_mem_wdata", bus.mem_wdata, 32'h5555_6666);
    nxt();
    clr_in();
    mid();
    chk("alt_wr_p_rvalid", 32'(bus.p_rvalid), 32'd0);
    chk("alt_wr_p_rdata", bus.p_rdata, 32'd0);
    nxt();

    // reset on the cycle after a read grant
    bus.p_req  = 1'b1;
    bus.p_addr = 32'h30;
    nxt();
    clr_in();
    reset         = 1'b0;
    bus.mem_rdata = 32'hCAFE_F00D;
    mid();
    chk("rmid_p_rvalid", 32'(bus.p_rvalid), 32'd0);
    chk("rmid_p_rdata", bus.p_rdata, 32'd0);
    nxt();
    reset = 1'b1;
    mid();
    chk("rrel_p_rvalid", 32'(bus.p_rvalid), 32'd0);
    nxt();
    bus.p_req  = 1'b1;
    bus.p_addr = 32'h34;
    nxt();
    clr_in();
    bus.mem_rdata = 32'h1234_5678;
    mid();
    chk("rnew_p_rvalid", 32'(bus.p_rvalid), 32'd1);
    chk("rnew_p_rdata", bus.p_rdata, 32'h1234_5678);
    nxt();
    clr_in();
    nxt();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
